// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, protection default and master states
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } master_state_t;

endpackage

// File: rtl/axi4_lite_cmd_master_if.sv
// rtl/axi4_lite_cmd_master_if.sv - AXI4-Lite bus bundle between the command master and its slave
interface axi4_lite_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_lite_cmd_master.sv
// rtl/axi4_lite_cmd_master.sv - single-outstanding AXI4-Lite master with command/response streams and watchdog
module axi4_lite_cmd_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    axi4_lite_cmd_master_if.master  axi
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    master_state_t           state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_W-1:0]        wd_count_q, wd_count_d;

    logic aw_fin, w_fin, expired, done, abort;

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        wd_count_d = wd_count_q + CNT_W'(1);
        done       = 1'b0;
        abort      = 1'b0;
        // A channel counts as finished once its valid has dropped or it handshakes this cycle
        aw_fin     = !awvalid_q || axi.awready;
        w_fin      = !wvalid_q || axi.wready;
        expired    = (wd_count_q == WD_LAST);

        case (state_q)
            IDLE: begin
                wd_count_d = '0;
                if (cmd_valid) begin
                    if (cmd_write) begin
                        state_d   = WR;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_fin && w_fin && axi.bvalid) begin
                    done   = 1'b1;
                    resp_d = axi.bresp;
                end else if (aw_fin && w_fin) begin
                    state_d   = WR_RESP;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end else begin
                    awvalid_d = awvalid_q && !axi.awready;
                    wvalid_d  = wvalid_q && !axi.wready;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    done   = 1'b1;
                    resp_d = axi.bresp;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            RD_ADDR: begin
                // Any R beat coinciding with the AR handshake is deliberately dropped
                if (axi.arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    done    = 1'b1;
                    resp_d  = axi.rresp;
                    rdata_d = axi.rdata;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done || abort) begin
            state_d   = RSP;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            timeout_d = abort;
        end
        if (done && (state_q == WR || state_q == WR_RESP)) begin
            rdata_d = '0;
        end
        if (abort) begin
            resp_d  = SLVERR;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            araddr_q   <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
            timeout_q  <= 1'b0;
            wd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            wd_count_q <= wd_count_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RSP);
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    assign axi.awaddr  = awaddr_q;
    assign axi.awprot  = AXI_PROT_DEFAULT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arprot  = AXI_PROT_DEFAULT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb/tb_axi4_lite_cmd_master.sv - table-driven scoreboard bench for the AXI4-Lite command master
module tb_axi4_lite_cmd_master;
    import axi4_lite_pkg::*;

    localparam int T = 8;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axi4_lite_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4_lite_cmd_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .axi(axi)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d;
        int          w_d;
        int          b_d;
        logic [1:0]  bresp;
        int          ar_d;
        int          r_d;
        logic        stray;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          hold;
        int          lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];
    vec_t vecs[12];
    vec_t cfg;
    int   slv_epoch = 0;
    int   errors = 0;
    int   checks = 0;

    int   seen_epoch = 0;
    int   aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit   aw_seen = 0, w_seen = 0, r_pending = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion before 100us");
        $fatal(1, "time limit reached");
    end

    // Slave model: decides this cycle's ready/valid at the falling edge, so handshakes land on the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (slv_epoch != seen_epoch) begin
                seen_epoch = slv_epoch;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                aw_seen = 0; w_seen = 0; r_pending = 0;
            end
            axi.awready = axi.awvalid && (aw_wait >= cfg.aw_d);
            if (axi.awvalid && !axi.awready) aw_wait++;
            if (axi.awvalid && axi.awready) begin aw_seen = 1; aw_wait = 0; end
            axi.wready = axi.wvalid && (w_wait >= cfg.w_d);
            if (axi.wvalid && !axi.wready) w_wait++;
            if (axi.wvalid && axi.wready) begin w_seen = 1; w_wait = 0; end
            axi.bvalid = 1'b0;
            axi.bresp  = 2'b00;
            if (aw_seen && w_seen) begin
                if (b_wait >= cfg.b_d) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = cfg.bresp;
                    if (axi.bready) begin aw_seen = 0; w_seen = 0; b_wait = 0; end
                end else begin
                    b_wait++;
                end
            end
            axi.rvalid = 1'b0;
            axi.rdata  = 32'h0;
            axi.rresp  = 2'b00;
            if (r_pending) begin
                if (r_wait >= cfg.r_d) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = cfg.rdata;
                    axi.rresp  = cfg.rresp;
                    r_pending  = 0;
                end else begin
                    r_wait++;
                end
            end
            axi.arready = axi.arvalid && (cfg.ar_d >= 0) && (ar_wait >= cfg.ar_d);
            if (axi.arvalid && !axi.arready) ar_wait++;
            if (axi.arvalid && axi.arready) begin
                ar_wait = 0; r_pending = 1; r_wait = 1;
                if (cfg.stray) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = 32'hDEADBEEF;
                    axi.rresp  = 2'b00;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input int awd, input int wdl, input int bd,
                                input logic [1:0] br, input int ard, input int rd, input logic st,
                                input logic [31:0] rdt, input logic [1:0] rr, input int hold,
                                input int lat, input logic [31:0] erd, input logic [1:0] ers,
                                input logic eto);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.wstrb = ws;
        v.aw_d = awd; v.w_d = wdl; v.b_d = bd; v.bresp = br;
        v.ar_d = ard; v.r_d = rd; v.stray = st; v.rdata = rdt; v.rresp = rr;
        v.hold = hold; v.lat = lat; v.exp_rdata = erd; v.exp_resp = ers; v.exp_to = eto;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        rsp_t e;
        int   k;
        bit   seen;
        int   aw_end, w_end, ar_end;
        aw_end = (v.aw_d + 1 < T) ? v.aw_d + 1 : T;
        w_end  = (v.w_d + 1 < T) ? v.w_d + 1 : T;
        ar_end = (v.ar_d < 0 || v.ar_d + 1 > T) ? T : v.ar_d + 1;
        cfg = v;
        slv_epoch++;
        check($sformatf("v%0d cmd_ready_idle", idx), cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        e.rdata = v.exp_rdata; e.resp = v.exp_resp; e.to = v.exp_to;
        exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        if (v.write) begin
            check($sformatf("v%0d awaddr", idx), axi.awaddr, v.addr);
            check($sformatf("v%0d wdata", idx), axi.wdata, v.wdata);
            check($sformatf("v%0d wstrb", idx), axi.wstrb, v.wstrb);
            check($sformatf("v%0d awprot", idx), axi.awprot, 0);
        end else begin
            check($sformatf("v%0d araddr", idx), axi.araddr, v.addr);
            check($sformatf("v%0d arprot", idx), axi.arprot, 0);
        end
        k = 1;
        seen = 0;
        while (!seen && k <= 40) begin
            if (rsp_valid) begin
                seen = 1;
            end else begin
                check($sformatf("v%0d c%0d cmd_ready", idx, k), cmd_ready, 0);
                check($sformatf("v%0d c%0d awvalid", idx, k), axi.awvalid, v.write && k <= aw_end);
                check($sformatf("v%0d c%0d wvalid", idx, k), axi.wvalid, v.write && k <= w_end);
                check($sformatf("v%0d c%0d bready", idx, k), axi.bready, v.write);
                check($sformatf("v%0d c%0d arvalid", idx, k), axi.arvalid, !v.write && k <= ar_end);
                check($sformatf("v%0d c%0d rready", idx, k), axi.rready, !v.write);
                step();
                k++;
            end
        end
        check($sformatf("v%0d rsp_seen", idx), seen, 1);
        if (!seen) begin
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d rsp_latency", idx), k, v.lat);
            check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, e.rdata);
            check($sformatf("v%0d rsp_resp", idx), rsp_resp, e.resp);
            check($sformatf("v%0d rsp_timeout", idx), rsp_timeout, e.to);
            check($sformatf("v%0d bus_quiet_in_rsp", idx),
                  {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
            for (int h = 1; h < v.hold; h++) begin
                step();
                check($sformatf("v%0d hold%0d rsp_valid", idx, h), rsp_valid, 1);
                check($sformatf("v%0d hold%0d rsp_rdata", idx, h), rsp_rdata, e.rdata);
                check($sformatf("v%0d hold%0d rsp_resp", idx, h), rsp_resp, e.resp);
                check($sformatf("v%0d hold%0d rsp_timeout", idx, h), rsp_timeout, e.to);
                check($sformatf("v%0d hold%0d cmd_ready", idx, h), cmd_ready, 0);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check($sformatf("v%0d post_rsp_valid", idx), rsp_valid, 0);
            check($sformatf("v%0d post_cmd_ready", idx), cmd_ready, 1);
        end
    endtask

    initial begin
        rsp_t e;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        cfg = mk(0, 0, 0, 0, 0, 0, 0, OKAY, 0, 1, 0, 0, OKAY, 0, 0, 0, OKAY, 0);

        //           wr addr      wdata         strb awd wd bd bresp  ard rd st rdata         rresp   hold lat exp_rdata     resp    to
        vecs[0]  = mk(1, 32'h04, 32'hCAFEF00D, 4'hF,  0, 0, 0, OKAY,    0, 1, 0, 32'h0,        OKAY,   0, 2, 32'h0,        OKAY,   0);
        vecs[1]  = mk(0, 32'h04, 32'h0,        4'h0,  0, 0, 0, OKAY,    0, 1, 0, 32'hCAFEF00D, OKAY,   0, 3, 32'hCAFEF00D, OKAY,   0);
        vecs[2]  = mk(1, 32'h10, 32'h11112222, 4'hF,  3, 0, 2, OKAY,    0, 1, 0, 32'h0,        OKAY,   0, 7, 32'h0,        OKAY,   0);
        vecs[3]  = mk(0, 32'h20, 32'h0,        4'h0,  0, 0, 0, OKAY,   -1, 1, 0, 32'hFFFFFFFF, OKAY,   0, 9, 32'h0,        SLVERR, 1);
        vecs[4]  = mk(1, 32'h30, 32'h55AA55AA, 4'hF,  0, 0, 0, DECERR,  0, 1, 0, 32'h0,        OKAY,   5, 2, 32'h0,        DECERR, 0);
        vecs[5]  = mk(0, 32'h34, 32'h0,        4'h0,  0, 0, 0, OKAY,    0, 3, 0, 32'h12345678, SLVERR, 2, 5, 32'h12345678, SLVERR, 0);
        vecs[6]  = mk(1, 32'h40, 32'hDEADBEEF, 4'hF, 100,0, 0, OKAY,    0, 1, 0, 32'h0,        OKAY,   0, 9, 32'h0,        SLVERR, 1);
        vecs[7]  = mk(0, 32'h44, 32'h0,        4'h0,  0, 0, 0, OKAY,    0, 7, 0, 32'hA5A50007, OKAY,   0, 9, 32'hA5A50007, OKAY,   0);
        vecs[8]  = mk(0, 32'h48, 32'h0,        4'h0,  0, 0, 0, OKAY,    0, 8, 0, 32'hA5A50008, OKAY,   0, 9, 32'h0,        SLVERR, 1);
        vecs[9]  = mk(1, 32'h4C, 32'h0000BEEF, 4'h3,  0, 0, 7, EXOKAY,  0, 1, 0, 32'h0,        OKAY,   0, 9, 32'h0,        EXOKAY, 0);
        vecs[10] = mk(1, 32'h50, 32'h01020304, 4'h5,  1, 2, 0, OKAY,    0, 1, 0, 32'h0,        OKAY,   0, 4, 32'h0,        OKAY,   0);
        vecs[11] = mk(0, 32'h54, 32'h0,        4'h0,  0, 0, 0, OKAY,    2, 2, 1, 32'h0BADCAFE, OKAY,   0, 6, 32'h0BADCAFE, OKAY,   0);

        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset cmd_ready", cmd_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        check("reset valids_readies",
              {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        check("reset awaddr", axi.awaddr, 0);
        check("reset wdata_wstrb", {axi.wdata, axi.wstrb}, 0);
        check("reset araddr", axi.araddr, 0);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while the write sits in WR_RESP waiting for a B that never comes
        cfg = mk(1, 32'h60, 32'h77777777, 4'hF, 0, 0, 100, OKAY, 0, 1, 0, 0, OKAY, 0, 0, 0, OKAY, 0);
        slv_epoch++;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60;
        cmd_wdata = 32'h77777777; cmd_wstrb = 4'hF;
        e.rdata = 32'h0; e.resp = OKAY; e.to = 1'b0;
        exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        step();
        check("rst_mid in_wr_resp", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        reset = 1'b1;
        step();
        check("rst_mid valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        check("rst_mid cmd_ready", cmd_ready, 1);
        check("rst_mid rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        exp_q.delete();
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("rst_after%0d rsp_valid", j), rsp_valid, 0);
            check($sformatf("rst_after%0d cmd_ready", j), cmd_ready, 1);
        end

        run_vec(12, vecs[1]);
        run_vec(13, vecs[0]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
